// File: rtl/srl_rr_arbiter_16.sv
// Round-robin arbiter and select sequencer for the 16:1 serial mux.
// Grants one source at a time for a bounded burst, back-to-back.
module srl_rr_arbiter_16 #(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        enable,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        active,
    output logic        last
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN - 1);

    state_t           state;
    state_t           state_nx;
    logic [3:0]       ptr;
    logic [3:0]       ptr_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       sel_nx;
    logic [15:0]      grant_nx;

    logic [3:0]       base;
    logic [15:0]      rot;
    logic [3:0]       off;
    logic [3:0]       win;
    logic             found;
    logic             start;
    logic             end_burst;

    // Circular priority search; at a burst end it starts just past the holder.
    always_comb begin
        base  = (state == GRANT) ? sel + 4'd1 : ptr;
        rot   = (req >> base) | (req << (5'd16 - {1'b0, base}));
        off   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) off = 4'(i);
        end
        win       = base + off;
        found     = |req;
        start     = found && enable;
        end_burst = (cnt == '0) || !req[sel];
    end

    // Next-state and next-register decode.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        sel_nx   = sel;
        grant_nx = grant;
        unique case (state)
            IDLE: begin
                grant_nx = '0;
                if (start) begin
                    sel_nx   = win;
                    grant_nx = 16'd1 << win;
                    cnt_nx   = CNT_LOAD;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!end_burst) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    ptr_nx = sel + 4'd1;
                    if (start) begin
                        sel_nx   = win;
                        grant_nx = 16'd1 << win;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        grant_nx = '0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                grant_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State, pointer, counter and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 4'd0;
            cnt   <= '0;
            sel   <= 4'd0;
            grant <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            sel   <= sel_nx;
            grant <= grant_nx;
        end
    end

    // Status flags decoded from registers only.
    always_comb begin
        active = (state == GRANT);
        last   = active && (cnt == '0);
    end

endmodule

// File: doc/srl_rr_arbiter_16.md
# srl_rr_arbiter_16

Round-robin arbiter and sequencer for the 16:1 serial mux datapath (`srl_mux_16to1`). It accepts up to 16 request lines, grants one requester at a time for a bounded burst of cycles, and drives the mux select `S[3:0]` so the granted input appears on `Z`. Back-to-back grants are issued with no idle cycle. The block sits between the serial sources and the mux select port.

## Interface

Parameters:
- `BURST_LEN`, default 8: maximum granted cycles per burst. Legal range is 1..255.
- `CNT_W`, default 8: width of the burst counter. It must hold `BURST_LEN-1`.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, 16: request lines. `req[i]` high means source i wants the mux.
- `enable`, input, 1: when low, no new grant is started. A burst in progress still runs to completion.
- `sel`, output, 4: index of the granted source. Connects to mux `S[3:0]`.
- `grant`, output, 16: one-hot grant vector. It is all-zero when no source is granted.
- `active`, output, 1: high while any grant is held.
- `last`, output, 1: high during the final permitted cycle of the current burst.

## Operation

Registered state:
- `state` is `IDLE` or `GRANT`.
- `ptr[3:0]` is the round-robin start index.
- `cnt[CNT_W-1:0]` is the burst cycles remaining.
- `sel`, `grant`.

Winner selection (combinational):
- Search `req` circularly starting at `ptr`: ptr, ptr+1, …, 15, 0, …, ptr-1, with mod-16 wrap.
- The winner is the first set bit found. `found` is high when `req` is nonzero.

Start condition: `start = found && enable`.

IDLE state:
- If `start`: load `sel` with the winner, set `grant` to one-hot(winner), load `cnt` with `BURST_LEN-1`, and go to GRANT.
- Otherwise stay in IDLE with `grant` = 0.

GRANT state:
- `end_burst = (cnt == 0) || !req[sel]`.
- If `end_burst` is low: decrement `cnt`. `sel` and `grant` hold.
- If `end_burst` is high: set `ptr` to `sel+1` (mod 16). Then:
  - If `start` holds, re-evaluated with the updated `ptr` (winner searched from `sel+1`): grant the new winner immediately, reload `cnt`, and stay in GRANT.
  - Otherwise clear `grant` and go to IDLE.
- The current holder can win again only if no other request is set. This is the wrap of the search back to `sel`.

Output rules:
- `active` = (state == GRANT). Equivalently, `grant != 0`.
- `last` = active && (`cnt` == 0). It is combinational from registers.
- In IDLE, `sel` holds its last value, and `Z` is don't-care downstream.
- `grant` is always zero or exactly one-hot, and always equals one-hot(`sel`) when `active`.

Boundary cases:
- `BURST_LEN`=1: every grant lasts exactly one cycle. `last` is high in every granted cycle.
- `req[sel]` dropping mid-burst ends the burst at the next edge. The cycle in which the request is low is still a granted cycle.
- `enable` falling mid-burst does not shorten the burst. At `end_burst`, the block goes to IDLE.
- Requests arriving during a burst are held off until `end_burst`. They are not queued beyond the level of `req`.

Reset (`rst_n` low, asynchronous, at any time including mid-burst):
- `state` = IDLE, `ptr` = 0, `cnt` = 0, `sel` = 0, `grant` = 0.
- `active` = 0, `last` = 0.

## Timing

- Grant latency: `req`/`enable` sampled at edge k produce `grant`/`sel`/`active` valid after edge k, so one cycle from request to grant.
- Full burst: `active` is high for exactly `BURST_LEN` cycles. `last` is high in the `BURST_LEN`-th cycle.
- Handover: the next grant is valid in the cycle right after `last`. There is no idle gap while any request is pending and `enable` is high.
- Early release: if `req[sel]` is low at edge m, the grant changes or clears after edge m.
- All outputs are glitch-free registered values, except `last` and `active`, which are decoded from registers only (never from `req`).

## Test plan

1. **Reset:** assert `rst_n`=0 mid-burst with `req`=16'hFFFF → `grant`=0, `sel`=0, `active`=0, `last`=0 immediately. After release, the first grant goes to source 0.
2. **Single requester:** `req`=16'h0020 held, `enable`=1, `BURST_LEN`=8 → `sel`=5, `grant`=16'h0020 one cycle later. `last` is high on the 8th cycle, and source 5 is re-granted back-to-back with no gap.
3. **All requesting:** `req`=16'hFFFF → grants go to sources 0,1,…,15,0 in order, 8 cycles each. `active` stays continuously high, with 16 `last` pulses per rotation.
4. **Early release and wrap:**
   - Set `ptr`=15 by granting source 14, then `req`=16'h8004.
   - Source 15 is granted; drop `req[15]` after 3 granted cycles → the grant moves to source 2 on the next edge.
   - `ptr` becomes 0, then 3 after source 2's burst.
5. **Enable gating:** drop `enable` during cycle 4 of a burst with `req`=16'h0003 → the burst completes all 8 cycles, `active` then falls to 0, and no grant is issued until `enable`=1. Then source 1 is granted.
6. **`BURST_LEN`=1 build:** `req`=16'h0101 → `grant` alternates 16'h0001 and 16'h0100 every cycle, with `last` constantly high.
